side_road_sensor: RTL

//  Side-road vehicle detector. It produces the request input `s` consumed by the traffic-light controller.
//  It synchronises and debounces the raw arrival and departure loop sensors, and keeps a saturating count of queued vehicles.
//  It holds `s` high until the controller grants side-road green (CG), then releases it when the queue drains.
//  It sits between the board sensor pins and the controller's `s` input.

---
 rtl/side_road_sensor.sv | 118 +++++++++++
 1 files changed

// File: rtl/side_road_sensor.sv
// Side-road vehicle detector: synchronises and debounces the arrival/departure loops,
// keeps a saturating queue count and drives the registered request `s` to the controller.
module side_road_sensor #(
    parameter int DEB_CYCLES = 4,
    parameter int CNT_W      = 4,
    parameter int MAX_Q      = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arrive_raw,
    input  logic             depart_raw,
    input  logic             CG,
    output logic             s,
    output logic [CNT_W-1:0] q_cnt,
    output logic             arrive_pulse,
    output logic             ovf
);

    localparam int             DW       = $clog2(DEB_CYCLES + 1);
    localparam logic [DW-1:0]  DEB_LAST = DW'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] MAX_Q_V = CNT_W'(MAX_Q);

    typedef enum logic [1:0] {IDLE, REQ, SERVE, GAP} state_t;

    // Channel 0 is the arrival loop, channel 1 the departure loop.
    logic [1:0]          sync1_q, sync2_q;
    logic [1:0]          level_q, level_d;
    logic [1:0][DW-1:0]  run_q, run_d;
    logic [1:0]          rise_q, rise_d;
    logic [CNT_W-1:0]    q_q, q_d;
    logic                ovf_q, ovf_d;
    state_t              state_q, state_d;
    logic                s_q, s_d;
    logic                dep_ok;

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        level_d = level_q;
        run_d   = run_q;
        rise_d  = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != level_q[i]) begin
                if (run_q[i] == DEB_LAST) begin
                    level_d[i] = sync2_q[i];
                    run_d[i]   = '0;
                    rise_d[i]  = sync2_q[i];
                end else begin
                    run_d[i] = run_q[i] + 1'b1;
                end
            end else begin
                run_d[i] = '0;
            end
        end
    end

    // A departure only counts while the side road is green and somebody is queued.
    assign dep_ok = rise_q[1] & CG & (q_q != '0);

    always_comb begin
        q_d   = q_q;
        ovf_d = ovf_q;
        if (rise_q[0] && !dep_ok) begin
            if (q_q < MAX_Q_V) q_d = q_q + 1'b1;
            else               ovf_d = 1'b1;
        end else if (!rise_q[0] && dep_ok) begin
            q_d = q_q - 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = 1'b0;
        case (state_q)
            IDLE:  if (q_q != '0) state_d = REQ;
            REQ: begin
                s_d = 1'b1;
                if (CG) state_d = SERVE;
            end
            SERVE: begin
                s_d = (q_q != '0);
                if (!CG) state_d = GAP;
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            run_q   <= '0;
            rise_q  <= '0;
            q_q     <= '0;
            ovf_q   <= 1'b0;
            state_q <= IDLE;
            s_q     <= 1'b0;
        end else begin
            sync1_q <= {depart_raw, arrive_raw};
            sync2_q <= sync1_q;
            level_q <= level_d;
            run_q   <= run_d;
            rise_q  <= rise_d;
            q_q     <= q_d;
            ovf_q   <= ovf_d;
            state_q <= state_d;
            s_q     <= s_d;
        end
    end

    assign s            = s_q;
    assign q_cnt        = q_q;
    assign arrive_pulse = rise_q[0];
    assign ovf          = ovf_q;

endmodule
